// File: rtl/bin_to_bcd_digits_if.sv
// Handshake and digit bus between a binary-value producer and the BCD converter.
// The master drives the request; the slave (converter) returns status and digits.
interface bin_to_bcd_digits_if #(
  parameter int BIN_WIDTH   = 14,
  parameter int DIGIT_WIDTH = 4
);
  logic                   start;
  logic [BIN_WIDTH-1:0]   bin_in;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic [DIGIT_WIDTH-1:0] digit3;
  logic [DIGIT_WIDTH-1:0] digit2;
  logic [DIGIT_WIDTH-1:0] digit1;
  logic [DIGIT_WIDTH-1:0] digit0;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, digit3, digit2, digit1, digit0
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, digit3, digit2, digit1, digit0
  );
endinterface

// File: rtl/bin_to_bcd_digits.sv
// Sequential double-dabble binary-to-BCD converter feeding the seven-segment display.
// Digit outputs only change on the final edge, so the display never shows scratch values.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// SHIFT  | one add-3/shift iteration per clock, BIN_WIDTH iterations
// FINISH | publish digits (or saturate to 9999) and pulse done
module bin_to_bcd_digits #(
  parameter int BIN_WIDTH   = 14,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bin_to_bcd_digits_if.slave   bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

  logic [1:0]             state;
  logic [BIN_WIDTH-1:0]   shift_reg;
  logic [15:0]            scratch;
  logic [15:0]            adjusted;
  logic [CNT_W-1:0]       iter_cnt;
  logic                   ovf_pending;
  logic                   busy_q;
  logic                   done_q;
  logic                   overflow_q;
  logic [DIGIT_WIDTH-1:0] digit3_q, digit2_q, digit1_q, digit0_q;

  // A nibble >= 5 becomes at most 12 after +3, so no carry crosses nibbles.
  always_comb begin
    adjusted = scratch;
    for (int n = 0; n < 4; n++) begin
      if (scratch[n*4 +: 4] >= 4'd5)
        adjusted[n*4 +: 4] = scratch[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      scratch     <= '0;
      iter_cnt    <= '0;
      ovf_pending <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      digit3_q    <= '0;
      digit2_q    <= '0;
      digit1_q    <= '0;
      digit0_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg   <= bus.bin_in;
            scratch     <= '0;
            iter_cnt    <= '0;
            ovf_pending <= (32'(bus.bin_in) > 32'd9999);
            busy_q      <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= {adjusted[14:0], shift_reg[BIN_WIDTH-1]};
          shift_reg <= {shift_reg[BIN_WIDTH-2:0], 1'b0};
          iter_cnt  <= iter_cnt + 1'b1;
          if (iter_cnt == LAST_ITER)
            state <= FINISH;
        end
        FINISH: begin
          if (ovf_pending) begin
            digit3_q   <= DIGIT_WIDTH'(9);
            digit2_q   <= DIGIT_WIDTH'(9);
            digit1_q   <= DIGIT_WIDTH'(9);
            digit0_q   <= DIGIT_WIDTH'(9);
            overflow_q <= 1'b1;
          end else begin
            digit3_q   <= scratch[15:12];
            digit2_q   <= scratch[11:8];
            digit1_q   <= scratch[7:4];
            digit0_q   <= scratch[3:0];
            overflow_q <= 1'b0;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.digit3   = digit3_q;
  assign bus.digit2   = digit2_q;
  assign bus.digit1   = digit1_q;
  assign bus.digit0   = digit0_q;
endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed bench for bin_to_bcd_digits: conversions, saturation, ignored starts,
// mid-conversion reset and back-to-back throughput.
module tb_bin_to_bcd_digits;
  localparam int BW = 14;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bin_to_bcd_digits_if #(.BIN_WIDTH(BW), .DIGIT_WIDTH(DW)) bus();

  bin_to_bcd_digits #(.BIN_WIDTH(BW), .DIGIT_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] digits();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, "_digits"}, 32'(digits()), 32'h0);
  endtask

  // Starts a conversion (edge E0) and returns right after E(BW+1) with done high.
  // Optionally re-asserts start with a different value before edge inject_at.
  task automatic convert(input string tag, input logic [BW-1:0] val,
                         input logic [15:0] exp_d, input logic exp_ovf,
                         input int inject_at, input logic [BW-1:0] inject_val);
    logic [15:0] prev_d;
    logic        prev_ovf;
    int          pulses;
    prev_d   = digits();
    prev_ovf = bus.overflow;
    pulses   = 0;
    bus.bin_in = val;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.bin_in = ~val;
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= BW; i++) begin
      if (i == inject_at) begin
        bus.start  = 1'b1;
        bus.bin_in = inject_val;
      end
      tick();
      bus.start = 1'b0;
      if (bus.done) pulses++;
      check({tag, "_busy_mid"}, 32'(bus.busy), 32'd1);
      check({tag, "_digits_hold"}, 32'(digits()), 32'(prev_d));
      check({tag, "_ovf_hold"}, 32'(bus.overflow), 32'(prev_ovf));
    end
    check({tag, "_early_done"}, 32'(pulses), 32'd0);
    tick();
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_digits"}, 32'(digits()), 32'(exp_d));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
  endtask

  task automatic done_drops(input string tag, input logic [15:0] exp_d);
    tick();
    check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_digits_kept"}, 32'(digits()), 32'(exp_d));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_idle_zero("reset");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle_zero("idle");
    end

    convert("c1234", 14'd1234, 16'h1234, 1'b0, -1, '0);
    done_drops("c1234", 16'h1234);

    convert("c0", 14'd0, 16'h0000, 1'b0, -1, '0);
    done_drops("c0", 16'h0000);
    convert("c9999", 14'd9999, 16'h9999, 1'b0, -1, '0);
    done_drops("c9999", 16'h9999);
    convert("c10000", 14'd10000, 16'h9999, 1'b1, -1, '0);
    done_drops("c10000", 16'h9999);
    convert("c16383", 14'd16383, 16'h9999, 1'b1, -1, '0);
    done_drops("c16383", 16'h9999);
    convert("c0807", 14'd807, 16'h0807, 1'b0, -1, '0);
    done_drops("c0807", 16'h0807);

    convert("ign", 14'd4321, 16'h4321, 1'b0, 5, 14'd5678);
    done_drops("ign", 16'h4321);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ign_no_second", 32'(bus.done), 32'd0);
    end

    // Leave the saturated result visible so the abort is seen to clear it.
    convert("pre_abort", 14'd12000, 16'h9999, 1'b1, -1, '0);
    done_drops("pre_abort", 16'h9999);
    bus.bin_in = 14'd8765;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    check("abort_busy_e0", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 6; i++) tick();
    reset = 1'b1;
    tick();
    check_idle_zero("abort_e7");
    reset = 1'b0;
    tick();
    check_idle_zero("abort_e8");
    for (int i = 0; i < BW + 2; i++) begin
      tick();
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    convert("c42", 14'd42, 16'h0042, 1'b0, -1, '0);
    done_drops("c42", 16'h0042);

    convert("b2b1", 14'd1111, 16'h1111, 1'b0, -1, '0);
    convert("b2b2", 14'd2222, 16'h2222, 1'b0, -1, '0);
    done_drops("b2b2", 16'h2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
